// File: rtl/des_round_ctrl.sv
// Iterative DES round controller: one Feistel round per clock.
// Holds the L/R halves and the 56-bit C/D key state, sequences the round
// count and applies the per-round C/D rotation. The f-function, PC2, IP and
// IP^-1 are external and combinational.
module des_round_ctrl #(
  parameter int ROUNDS       = 16,   // 1..16; 16 for standard DES
  parameter bit ZERO_ON_IDLE = 1'b1  // 1: o_Data reads 0 while o_Valid is low
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Valid,
  output logic        o_Ready,
  input  logic        i_Decrypt,
  input  logic [63:0] i_Data,
  input  logic [55:0] i_Key56,
  output logic [31:0] o_FR,
  output logic [55:0] o_CD,
  input  logic [31:0] i_FOut,
  output logic [3:0]  o_Round,
  output logic        o_Busy,
  output logic        o_Valid,
  input  logic        i_Ready,
  output logic [63:0] o_Data,
  output logic [1:0]  o_State
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(ROUNDS - 1);

  state_t      state;
  logic [31:0] l_q;
  logic [31:0] r_q;
  logic [55:0] cd_q;
  logic [3:0]  cnt_q;
  logic        dec_q;
  logic        valid_q;
  logic        busy_q;
  logic        accept;
  logic [4:0]  next_round;

  // Rotation of one 28-bit key half ahead of 1-based round rnd.
  // Encrypt rotates left (1 or 2); decrypt walks the same schedule backwards
  // by rotating right, with no rotation before round 1.
  function automatic logic [27:0] rot_half(input logic [27:0] x,
                                           input logic [4:0]  rnd,
                                           input logic        dec);
    logic single;
    single = (rnd == 5'd1) || (rnd == 5'd2) || (rnd == 5'd9) || (rnd == 5'd16);
    if (!dec)
      rot_half = single ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    else if (rnd == 5'd1)
      rot_half = x;
    else
      rot_half = single ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  // C and D rotate independently.
  function automatic logic [55:0] rot_cd(input logic [55:0] cd,
                                         input logic [4:0]  rnd,
                                         input logic        dec);
    rot_cd = {rot_half(cd[55:28], rnd, dec), rot_half(cd[27:0], rnd, dec)};
  endfunction

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. Input side: o_Ready is high in IDLE, and in DONE when the
  // result is being consumed on the same edge (back-to-back); low in ROUND,
  // so i_Valid there is ignored. Output side: o_Valid stays high with o_Data
  // stable until the edge where i_Ready is high. o_Ready is low while reset
  // is asserted.
  assign o_Ready    = i_Rst_n & ((state == S_IDLE) | ((state == S_DONE) & i_Ready));
  assign accept     = i_Valid & o_Ready;
  assign next_round = {1'b0, cnt_q} + 5'd2;

  // Round FSM with all datapath state; L/R change only on accept or in ROUND.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state   <= S_IDLE;
      l_q     <= '0;
      r_q     <= '0;
      cd_q    <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (accept) begin
      l_q     <= i_Data[63:32];
      r_q     <= i_Data[31:0];
      cd_q    <= rot_cd(i_Key56, 5'd1, i_Decrypt);
      cnt_q   <= '0;
      dec_q   <= i_Decrypt;
      valid_q <= 1'b0;
      busy_q  <= 1'b1;
      state   <= S_ROUND;
    end else begin
      case (state)
        S_ROUND: begin
          l_q <= r_q;
          r_q <= l_q ^ i_FOut;
          if (cnt_q == LAST_CNT) begin
            // CD holds after the final round; count parks at 0.
            cnt_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= S_DONE;
          end else begin
            cd_q  <= rot_cd(cd_q, next_round, dec_q);
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_DONE: begin
          if (i_Ready) begin
            valid_q <= 1'b0;
            state   <= S_IDLE;
          end
        end
        S_IDLE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_FR    = r_q;
  assign o_CD    = cd_q;
  assign o_Round = cnt_q;
  assign o_Busy  = busy_q;
  assign o_Valid = valid_q;
  assign o_State = state;

  // Preoutput is {R16, L16}; optionally blanked while no result is valid.
  generate
    if (ZERO_ON_IDLE) begin : g_zero_idle
      assign o_Data = valid_q ? {r_q, l_q} : 64'd0;
    end else begin : g_raw_idle
      assign o_Data = {r_q, l_q};
    end
  endgenerate

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: software DES model supplies f/PC1/PC2/IP/FP and
// the expected preoutputs; results are queued at stimulus time and popped
// when the DUT raises o_Valid.
module tb_des_round_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [63:0] exp_q[$];

  // ---------------- DES tables ----------------
  int ip_t [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int fp_t [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                    34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  int e_t [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int p_t [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                    2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  int pc1_t [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                     10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int sh_t [16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int sb_t [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  // ---------------- DES model ----------------
  function automatic logic [63:0] ip_fn(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[63-i] = x[64-ip_t[i]];
    return r;
  endfunction

  function automatic logic [63:0] fp_fn(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[63-i] = x[64-fp_t[i]];
    return r;
  endfunction

  function automatic logic [55:0] pc1_fn(input logic [63:0] x);
    logic [55:0] r;
    for (int i = 0; i < 56; i++) r[55-i] = x[64-pc1_t[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2_fn(input logic [55:0] x);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[47-i] = x[56-pc2_t[i]];
    return r;
  endfunction

  function automatic logic [31:0] f_fn(input logic [31:0] rin, input logic [47:0] k);
    logic [47:0] ex;
    logic [31:0] sb;
    logic [31:0] r;
    logic [5:0]  b;
    int row, col, v;
    for (int i = 0; i < 48; i++) ex[47-i] = rin[32-e_t[i]];
    ex = ex ^ k;
    for (int s = 0; s < 8; s++) begin
      b   = ex[47-6*s -: 6];
      row = 2 * int'(b[5]) + int'(b[0]);
      col = int'(b[4:1]);
      v   = sb_t[s*64 + row*16 + col];
      sb[31-4*s -: 4] = v[3:0];
    end
    for (int i = 0; i < 32; i++) r[31-i] = sb[32-p_t[i]];
    return r;
  endfunction

  // Full 16 rounds on a post-IP block and post-PC1 key; returns {R16,L16}.
  function automatic logic [63:0] des_core(input logic [55:0] cd, input logic [63:0] blk,
                                           input logic dec);
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [31:0] l, r, t;
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < sh_t[i]; j++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      ks[i] = pc2_fn({c, d});
    end
    l = blk[63:32];
    r = blk[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ f_fn(r, dec ? ks[15-i] : ks[i]);
      l = t;
    end
    return {r, l};
  endfunction

  // Single round (ROUNDS=1): {L0^f(R0,K1), R0}.
  function automatic logic [63:0] one_round(input logic [55:0] cd, input logic [63:0] blk,
                                            input logic dec);
    logic [27:0] c, d;
    c = cd[55:28];
    d = cd[27:0];
    if (!dec) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    return {blk[63:32] ^ f_fn(blk[31:0], pc2_fn({c, d})), blk[31:0]};
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [55:0] rand56();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[55:0];
  endfunction

  // ---------------- DUT A: ROUNDS=16, ZERO_ON_IDLE=1 ----------------
  logic        a_valid, a_ready, a_dec, a_busy, a_ovalid, a_iready;
  logic [63:0] a_data, a_odata;
  logic [55:0] a_key, a_cd;
  logic [31:0] a_fr, a_fout;
  logic [3:0]  a_round;
  logic [1:0]  a_state;

  assign a_fout = f_fn(a_fr, pc2_fn(a_cd));

  des_round_ctrl #(.ROUNDS(16), .ZERO_ON_IDLE(1'b1)) dut_a (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(a_valid), .o_Ready(a_ready),
    .i_Decrypt(a_dec), .i_Data(a_data), .i_Key56(a_key), .o_FR(a_fr), .o_CD(a_cd),
    .i_FOut(a_fout), .o_Round(a_round), .o_Busy(a_busy), .o_Valid(a_ovalid),
    .i_Ready(a_iready), .o_Data(a_odata), .o_State(a_state)
  );

  // ---------------- DUT B: ROUNDS=1, ZERO_ON_IDLE=0 ----------------
  logic        b_valid, b_ready, b_dec, b_busy, b_ovalid, b_iready;
  logic [63:0] b_data, b_odata;
  logic [55:0] b_key, b_cd;
  logic [31:0] b_fr, b_fout;
  logic [3:0]  b_round;
  logic [1:0]  b_state;

  assign b_fout = f_fn(b_fr, pc2_fn(b_cd));

  des_round_ctrl #(.ROUNDS(1), .ZERO_ON_IDLE(1'b0)) dut_b (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(b_valid), .o_Ready(b_ready),
    .i_Decrypt(b_dec), .i_Data(b_data), .i_Key56(b_key), .o_FR(b_fr), .o_CD(b_cd),
    .i_FOut(b_fout), .o_Round(b_round), .o_Busy(b_busy), .o_Valid(b_ovalid),
    .i_Ready(b_iready), .o_Data(b_odata), .o_State(b_state)
  );

  // Per-cycle observations of DUT A after an accept (index = cycles after accept).
  logic [55:0] cd_log   [32];
  logic [3:0]  rnd_log  [32];
  logic [63:0] dat_log  [32];
  logic        busy_log [32];
  logic        rdy_log  [32];

  // ---------------- driver tasks ----------------
  // Called at a negedge: present a block and hold it until o_Ready is seen.
  task automatic send_a(input logic [63:0] blk, input logic [55:0] cd, input logic dec);
    int waited;
    exp_q.push_back(des_core(cd, blk, dec));
    waited  = 0;
    a_valid = 1'b1;
    a_data  = blk;
    a_key   = cd;
    a_dec   = dec;
    #1;
    while (!a_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    vec_cnt++;
    if (a_ready !== 1'b1) begin
      $display("FAIL accept_wait: o_Ready=%b, required 1", a_ready);
      err_cnt++;
    end
  endtask

  // From the accept cycle, count cycles until o_Valid, logging outputs.
  task automatic collect(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        a_valid = 1'b0;
        a_data  = rand64();
        a_key   = rand56();
        a_dec   = 1'($urandom_range(0, 1));
      end
      if (lat < 32) begin
        cd_log[lat]   = a_cd;
        rnd_log[lat]  = a_round;
        dat_log[lat]  = a_odata;
        busy_log[lat] = a_busy;
        rdy_log[lat]  = a_ready;
      end
    end while (!a_ovalid && lat < 100);
    vec_cnt++;
    if (a_ovalid !== 1'b1) begin
      $display("FAIL valid_wait: o_Valid=%b after %0d cycles, required 1", a_ovalid, lat);
      err_cnt++;
    end
  endtask

  task automatic check_result(input string name);
    logic [63:0] exp;
    vec_cnt++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: o_Data=%h with no expected entry queued", name, a_odata);
      err_cnt++;
    end else begin
      exp = exp_q.pop_front();
      if (a_odata !== exp) begin
        $display("FAIL %s: o_Data=%h, required %h", name, a_odata, exp);
        err_cnt++;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    a_valid = 0; a_dec = 0; a_data = '0; a_key = '0; a_iready = 1;
    b_valid = 0; b_dec = 0; b_data = '0; b_key = '0; b_iready = 1;
    #1 rst_n = 1'b0;
    #11;
    vec_cnt++;
    if ({a_ovalid, a_busy, a_round, a_state} !== 8'd0) begin
      $display("FAIL reset_ctrl: valid/busy/round/state=%b, required 0", {a_ovalid, a_busy, a_round, a_state});
      err_cnt++;
    end
    vec_cnt++;
    if ({a_odata, a_fr, a_cd} !== 152'd0) begin
      $display("FAIL reset_data: o_Data=%h o_FR=%h o_CD=%h, required 0", a_odata, a_fr, a_cd);
      err_cnt++;
    end
    vec_cnt++;
    if (a_ready !== 1'b0) begin
      $display("FAIL reset_ready: o_Ready=%b during reset, required 0", a_ready);
      err_cnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      $display("FAIL reset_release_ready: o_Ready a=%b b=%b, required 1", a_ready, b_ready);
      err_cnt++;
    end
  endtask

  task automatic test_encrypt();
    int lat;
    send_a(ip_fn(64'h0123456789ABCDEF), pc1_fn(64'h133457799BBCDFF1), 1'b0);
    collect(lat);
    vec_cnt++;
    if (lat != 17) begin
      $display("FAIL enc_latency: %0d cycles, required 17", lat);
      err_cnt++;
    end
    vec_cnt++;
    if (fp_fn(a_odata) !== 64'h85E813540F0AB405) begin
      $display("FAIL enc_ct: %h, required 85e813540f0ab405", fp_fn(a_odata));
      err_cnt++;
    end
    check_result("enc_preoutput");
    vec_cnt++;
    if (busy_log[1] !== 1'b1 || rdy_log[1] !== 1'b0) begin
      $display("FAIL enc_round_flags: busy=%b ready=%b, required 1/0", busy_log[1], rdy_log[1]);
      err_cnt++;
    end
    for (int k = 1; k <= 16; k++) begin
      vec_cnt++;
      if (rnd_log[k] !== 4'(k - 1) || dat_log[k] !== 64'd0) begin
        $display("FAIL enc_round_%0d: o_Round=%0d o_Data=%h, required %0d and 0", k, rnd_log[k], dat_log[k], k - 1);
        err_cnt++;
      end
    end
    @(negedge clk);
    vec_cnt++;
    if ({a_state, a_ovalid, a_ready} !== 4'b0001 || a_odata !== 64'd0) begin
      $display("FAIL enc_to_idle: state=%0d valid=%b ready=%b data=%h, required 0/0/1/0",
               a_state, a_ovalid, a_ready, a_odata);
      err_cnt++;
    end
  endtask

  task automatic test_decrypt();
    int lat;
    send_a(ip_fn(64'h85E813540F0AB405), pc1_fn(64'h133457799BBCDFF1), 1'b1);
    collect(lat);
    vec_cnt++;
    if (lat != 17) begin
      $display("FAIL dec_latency: %0d cycles, required 17", lat);
      err_cnt++;
    end
    vec_cnt++;
    if (cd_log[1] !== pc1_fn(64'h133457799BBCDFF1)) begin
      $display("FAIL dec_cd_round0: %h, required %h", cd_log[1], pc1_fn(64'h133457799BBCDFF1));
      err_cnt++;
    end
    vec_cnt++;
    if (fp_fn(a_odata) !== 64'h0123456789ABCDEF) begin
      $display("FAIL dec_pt: %h, required 0123456789abcdef", fp_fn(a_odata));
      err_cnt++;
    end
    check_result("dec_preoutput");
    @(negedge clk);
  endtask

  task automatic test_schedule();
    int lat;
    logic [27:0] ce, de;
    send_a(rand64(), {28'h0000001, 28'h0000001}, 1'b0);
    collect(lat);
    ce = 28'h0000001;
    de = 28'h0000001;
    for (int r = 0; r < 16; r++) begin
      for (int j = 0; j < sh_t[r]; j++) begin
        ce = {ce[26:0], ce[27]};
        de = {de[26:0], de[27]};
      end
      vec_cnt++;
      if (cd_log[r+1] !== {ce, de}) begin
        $display("FAIL sched_round_%0d: o_CD=%h, required %h", r, cd_log[r+1], {ce, de});
        err_cnt++;
      end
    end
    check_result("sched_preoutput");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic dec;
    a_iready = 1'b1;
    send_a(rand64(), rand56(), 1'b0);
    collect(lat);
    for (int i = 0; i < 5; i++) begin
      check_result("b2b_result");
      dec = 1'($urandom_range(0, 1));
      send_a(rand64(), rand56(), dec);
      collect(lat);
      vec_cnt++;
      if (lat != 17) begin
        $display("FAIL b2b_latency_%0d: %0d cycles, required 17", i, lat);
        err_cnt++;
      end
    end
    check_result("b2b_last");
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [63:0] held;
    logic [55:0] ncd;
    a_iready = 1'b0;
    send_a(rand64(), rand56(), 1'b1);
    collect(lat);
    held = a_odata;
    check_result("bp_result");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_valid = 1'($urandom_range(0, 1));
      a_data  = rand64();
      a_key   = rand56();
      #1;
      vec_cnt++;
      if (a_odata !== held || a_ready !== 1'b0 || a_ovalid !== 1'b1) begin
        $display("FAIL bp_hold_%0d: data=%h ready=%b valid=%b, required %h/0/1",
                 i, a_odata, a_ready, a_ovalid, held);
        err_cnt++;
      end
    end
    @(negedge clk);
    a_iready = 1'b1;
    ncd = rand56();
    send_a(rand64(), ncd, 1'b0);
    vec_cnt++;
    if (a_state !== 2'd2) begin
      $display("FAIL bp_accept_state: state=%0d at accept, required 2 (DONE)", a_state);
      err_cnt++;
    end
    collect(lat);
    vec_cnt++;
    if (busy_log[1] !== 1'b1 || rnd_log[1] !== 4'd0 ||
        cd_log[1] !== {ncd[54:28], ncd[55], ncd[26:0], ncd[27]}) begin
      $display("FAIL bp_new_block: busy=%b round=%0d cd=%h, required 1/0/%h",
               busy_log[1], rnd_log[1], cd_log[1], {ncd[54:28], ncd[55], ncd[26:0], ncd[27]});
      err_cnt++;
    end
    vec_cnt++;
    if (lat != 17) begin
      $display("FAIL bp_latency: %0d cycles, required 17", lat);
      err_cnt++;
    end
    check_result("bp_new_result");
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    int lat;
    send_a(ip_fn(64'h0123456789ABCDEF), pc1_fn(64'h133457799BBCDFF1), 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) a_valid = 1'b0;
    end while (a_round !== 4'd7 && n < 40);
    vec_cnt++;
    if (a_round !== 4'd7) begin
      $display("FAIL rst_mid_reach: o_Round=%0d, required 7", a_round);
      err_cnt++;
    end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({a_ovalid, a_busy, a_round, a_state, a_ready} !== 9'd0 ||
        {a_odata, a_fr, a_cd} !== 152'd0) begin
      $display("FAIL rst_mid_outputs: valid=%b busy=%b round=%0d ready=%b data=%h fr=%h cd=%h, required 0",
               a_ovalid, a_busy, a_round, a_ready, a_odata, a_fr, a_cd);
      err_cnt++;
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (a_ovalid !== 1'b0 || a_state !== 2'd0) begin
      $display("FAIL rst_mid_release: valid=%b state=%0d, required 0/0", a_ovalid, a_state);
      err_cnt++;
    end
    send_a(ip_fn(64'h0123456789ABCDEF), pc1_fn(64'h133457799BBCDFF1), 1'b0);
    collect(lat);
    vec_cnt++;
    if (fp_fn(a_odata) !== 64'h85E813540F0AB405) begin
      $display("FAIL rst_mid_ct: %h, required 85e813540f0ab405", fp_fn(a_odata));
      err_cnt++;
    end
    check_result("rst_mid_preoutput");
    @(negedge clk);
  endtask

  task automatic test_rounds1();
    int lat;
    logic [63:0] blk, exp;
    logic [55:0] cd;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      blk = rand64();
      cd  = rand56();
      exp_q.push_back(one_round(cd, blk, 1'(i % 2)));
      b_valid = 1'b1;
      b_data  = blk;
      b_key   = cd;
      b_dec   = 1'(i % 2);
      #1;
      vec_cnt++;
      if (b_ready !== 1'b1) begin
        $display("FAIL r1_ready_%0d: o_Ready=%b, required 1", i, b_ready);
        err_cnt++;
      end
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
        if (lat == 1) begin
          b_valid = 1'b0;
          b_data  = rand64();
          vec_cnt++;
          if (b_busy !== 1'b1 || b_round !== 4'd0) begin
            $display("FAIL r1_round_%0d: busy=%b round=%0d, required 1/0", i, b_busy, b_round);
            err_cnt++;
          end
        end
      end while (!b_ovalid && lat < 20);
      vec_cnt++;
      if (lat != 2 || b_ovalid !== 1'b1) begin
        $display("FAIL r1_latency_%0d: %0d cycles valid=%b, required 2/1", i, lat, b_ovalid);
        err_cnt++;
      end
      exp = (exp_q.size() > 0) ? exp_q[0] : 64'd0;
      vec_cnt++;
      if (exp_q.size() == 0 || b_odata !== exp) begin
        $display("FAIL r1_data_%0d: o_Data=%h, required %h", i, b_odata, exp);
        err_cnt++;
      end
      if (exp_q.size() > 0) exp_q.pop_front();
      @(negedge clk);
      vec_cnt++;
      if (b_state !== 2'd0 || b_ovalid !== 1'b0 || b_odata !== exp) begin
        $display("FAIL r1_idle_raw_%0d: state=%0d valid=%b data=%h, required 0/0/%h",
                 i, b_state, b_ovalid, b_odata, exp);
        err_cnt++;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    @(negedge clk);
    test_encrypt();
    test_decrypt();
    test_schedule();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_rounds1();
    vec_cnt++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      err_cnt++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
